// File: rtl/vram_arbiter_if.sv
// Bus bundle between the display fetch, the CPU port, the arbiter and the video RAM.
// The arbiter uses the slave view; the requesters and the RAM together use the master view.
interface vram_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output disp_data, disp_valid, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  disp_data, disp_valid, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Video RAM arbiter: display fetch has absolute priority, the CPU gets one outstanding
// access at a time. RAM-side outputs are registered; read data is steered by an owner tag.
module vram_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    vram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WR_ACK, RD_WAIT, RD_ACK} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_CPU} owner_t;

    state_t state, state_n;
    logic   cnt, cnt_n;
    owner_t tag0, tag1;
    logic   disp_gnt, cpu_gnt;

    always_comb begin
        disp_gnt = bus.disp_req;
        cpu_gnt  = !bus.disp_req && bus.cpu_req && (state == IDLE);
        state_n  = state;
        cnt_n    = cnt;
        case (state)
            IDLE: begin
                cnt_n = 1'b0;
                if (cpu_gnt) state_n = bus.cpu_we ? WR_ACK : RD_WAIT;
            end
            WR_ACK: state_n = IDLE;
            RD_WAIT: begin
                // two cycles: address out, then data back from RAM
                if (cnt) state_n = RD_ACK;
                cnt_n = 1'b1;
            end
            RD_ACK: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ram_addr   <= '0;
            bus.ram_we     <= 1'b0;
            bus.ram_wdata  <= '0;
            bus.disp_data  <= '0;
            bus.disp_valid <= 1'b0;
            bus.cpu_ack    <= 1'b0;
            bus.cpu_rdata  <= '0;
            tag0           <= OWN_NONE;
            tag1           <= OWN_NONE;
        end else begin
            if (disp_gnt) begin
                bus.ram_addr <= bus.disp_addr;
                bus.ram_we   <= 1'b0;
                tag0         <= OWN_DISP;
            end else if (cpu_gnt) begin
                bus.ram_addr  <= bus.cpu_addr;
                bus.ram_we    <= bus.cpu_we;
                bus.ram_wdata <= bus.cpu_wdata;
                tag0          <= bus.cpu_we ? OWN_NONE : OWN_CPU;
            end else begin
                bus.ram_we <= 1'b0;
                tag0       <= OWN_NONE;
            end
            // tag1 lines up with ram_rdata returning for the access issued last cycle
            tag1           <= tag0;
            bus.disp_valid <= (tag1 == OWN_DISP);
            if (tag1 == OWN_DISP) bus.disp_data <= bus.ram_rdata;
            if (tag1 == OWN_CPU)  bus.cpu_rdata <= bus.ram_rdata;
            bus.cpu_ack <= (state_n == WR_ACK) || (state_n == RD_ACK);
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM.
module tb_vram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] mem [0:8191];

    vram_arbiter_if #(.ADDR_W(13), .DATA_W(8)) bus ();

    vram_arbiter #(.ADDR_W(13), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // synchronous RAM: read data one cycle after address
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[13'h0010] = 8'hA5;
        mem[13'h0000] = 8'h11;
        mem[13'h0001] = 8'h22;
        mem[13'h0020] = 8'h33;
        mem[13'h0021] = 8'h44;
        mem[13'h0300] = 8'h77;
        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;

        // reset state
        step(); step(); step();
        chk("rst_ram_we",     16'(bus.ram_we),     16'h0);
        chk("rst_ram_addr",   16'(bus.ram_addr),   16'h0);
        chk("rst_ram_wdata",  16'(bus.ram_wdata),  16'h0);
        chk("rst_disp_valid", 16'(bus.disp_valid), 16'h0);
        chk("rst_disp_data",  16'(bus.disp_data),  16'h0);
        chk("rst_cpu_ack",    16'(bus.cpu_ack),    16'h0);
        chk("rst_cpu_rdata",  16'(bus.cpu_rdata),  16'h0);
        rst = 1'b0;
        step(); step();

        // display only
        bus.disp_req = 1'b1; bus.disp_addr = 13'h0010;
        step();
        chk("disp_ram_addr", 16'(bus.ram_addr), 16'h0010);
        chk("disp_ram_we",   16'(bus.ram_we),   16'h0);
        chk("disp_valid_t1", 16'(bus.disp_valid), 16'h0);
        bus.disp_req = 1'b0;
        step();
        chk("disp_valid_t2", 16'(bus.disp_valid), 16'h0);
        chk("disp_ack_t2",   16'(bus.cpu_ack),    16'h0);
        step();
        chk("disp_valid_t3", 16'(bus.disp_valid), 16'h1);
        chk("disp_data_t3",  16'(bus.disp_data),  16'h00A5);
        chk("disp_ack_t3",   16'(bus.cpu_ack),    16'h0);
        step();
        chk("disp_valid_t4", 16'(bus.disp_valid), 16'h0);

        // CPU write
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0100; bus.cpu_wdata = 8'h3C;
        step();
        chk("wr_ram_we",    16'(bus.ram_we),    16'h1);
        chk("wr_ram_addr",  16'(bus.ram_addr),  16'h0100);
        chk("wr_ram_wdata", 16'(bus.ram_wdata), 16'h003C);
        chk("wr_ack",       16'(bus.cpu_ack),   16'h1);
        bus.cpu_req = 1'b0;
        step();
        chk("wr_ram_we_off", 16'(bus.ram_we),  16'h0);
        chk("wr_ack_off",    16'(bus.cpu_ack), 16'h0);

        // CPU read back
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0100;
        step();
        chk("rd_ram_addr", 16'(bus.ram_addr), 16'h0100);
        chk("rd_ram_we",   16'(bus.ram_we),   16'h0);
        chk("rd_ack_t1",   16'(bus.cpu_ack),  16'h0);
        step();
        chk("rd_ack_t2", 16'(bus.cpu_ack), 16'h0);
        step();
        chk("rd_ack_t3",   16'(bus.cpu_ack),   16'h1);
        chk("rd_rdata_t3", 16'(bus.cpu_rdata), 16'h003C);
        bus.cpu_req = 1'b0;
        step();
        chk("rd_ack_t4", 16'(bus.cpu_ack), 16'h0);

        // collision: display wins, CPU follows
        bus.disp_req = 1'b1; bus.disp_addr = 13'h0000;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0001;
        step();
        chk("col_addr_t1", 16'(bus.ram_addr), 16'h0000);
        bus.disp_req = 1'b0;
        step();
        chk("col_addr_t2", 16'(bus.ram_addr), 16'h0001);
        step();
        chk("col_dvalid_t3", 16'(bus.disp_valid), 16'h1);
        chk("col_ddata_t3",  16'(bus.disp_data),  16'h0011);
        chk("col_ack_t3",    16'(bus.cpu_ack),    16'h0);
        step();
        chk("col_ack_t4",    16'(bus.cpu_ack),    16'h1);
        chk("col_rdata_t4",  16'(bus.cpu_rdata),  16'h0022);
        chk("col_dvalid_t4", 16'(bus.disp_valid), 16'h0);
        bus.cpu_req = 1'b0;
        step();

        // interleave: CPU read, then display during the wait
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0020;
        step();
        bus.disp_req = 1'b1; bus.disp_addr = 13'h0021;
        step();
        chk("il_addr_t2", 16'(bus.ram_addr), 16'h0021);
        bus.disp_req = 1'b0;
        step();
        chk("il_ack_t3",    16'(bus.cpu_ack),    16'h1);
        chk("il_rdata_t3",  16'(bus.cpu_rdata),  16'h0033);
        chk("il_dvalid_t3", 16'(bus.disp_valid), 16'h0);
        bus.cpu_req = 1'b0;
        step();
        chk("il_dvalid_t4", 16'(bus.disp_valid), 16'h1);
        chk("il_ddata_t4",  16'(bus.disp_data),  16'h0044);
        chk("il_ack_t4",    16'(bus.cpu_ack),    16'h0);
        step();

        // held request: two writes with one idle cycle between
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0200; bus.cpu_wdata = 8'h5A;
        step();
        chk("hold_we_t1",  16'(bus.ram_we),  16'h1);
        chk("hold_ack_t1", 16'(bus.cpu_ack), 16'h1);
        step();
        chk("hold_we_t2",  16'(bus.ram_we),  16'h0);
        chk("hold_ack_t2", 16'(bus.cpu_ack), 16'h0);
        step();
        chk("hold_we_t3",  16'(bus.ram_we),  16'h1);
        chk("hold_ack_t3", 16'(bus.cpu_ack), 16'h1);
        bus.cpu_req = 1'b0;
        step();
        chk("hold_we_t4",  16'(bus.ram_we),  16'h0);
        chk("hold_ack_t4", 16'(bus.cpu_ack), 16'h0);

        // reset in the cycle after a read grant
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0300;
        step();
        chk("mr_addr_t1", 16'(bus.ram_addr), 16'h0300);
        rst = 1'b1;
        step();
        chk("mr_ram_addr",   16'(bus.ram_addr),   16'h0);
        chk("mr_ram_we",     16'(bus.ram_we),     16'h0);
        chk("mr_ram_wdata",  16'(bus.ram_wdata),  16'h0);
        chk("mr_cpu_ack",    16'(bus.cpu_ack),    16'h0);
        chk("mr_cpu_rdata",  16'(bus.cpu_rdata),  16'h0);
        chk("mr_disp_valid", 16'(bus.disp_valid), 16'h0);
        chk("mr_disp_data",  16'(bus.disp_data),  16'h0);
        rst = 1'b0;
        step();
        chk("mr2_addr_t1", 16'(bus.ram_addr), 16'h0300);
        chk("mr2_ack_t1",  16'(bus.cpu_ack),  16'h0);
        step();
        chk("mr2_ack_t2",  16'(bus.cpu_ack),  16'h0);
        step();
        chk("mr2_ack_t3",   16'(bus.cpu_ack),   16'h1);
        chk("mr2_rdata_t3", 16'(bus.cpu_rdata), 16'h0077);
        bus.cpu_req = 1'b0;
        step();
        chk("mr2_ack_t4", 16'(bus.cpu_ack), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
